// File: rtl/rect_pkg.sv
// Shared types and constants for the rectangle rasteriser and related plot-path blocks.
package rect_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    EMIT = 1'b1
  } rect_state_t;

  localparam logic MODE_FILL    = 1'b0;
  localparam logic MODE_OUTLINE = 1'b1;

endpackage

// File: rtl/rect_corner_norm.sv
// Combinational corner normalisation: sorts two corners into min/max x and y bounds.
module rect_corner_norm #(
  parameter int COORD_W = 16
) (
  input  logic [COORD_W-1:0] x0,
  input  logic [COORD_W-1:0] y0,
  input  logic [COORD_W-1:0] x1,
  input  logic [COORD_W-1:0] y1,
  output logic [COORD_W-1:0] xmin,
  output logic [COORD_W-1:0] xmax,
  output logic [COORD_W-1:0] ymin,
  output logic [COORD_W-1:0] ymax
);

  assign xmin = (x0 < x1) ? x0 : x1;
  assign xmax = (x0 < x1) ? x1 : x0;
  assign ymin = (y0 < y1) ? y0 : y1;
  assign ymax = (y0 < y1) ? y1 : y0;

endmodule

// File: rtl/rect_raster.sv
// Rectangle rasteriser: walks a normalised rectangle in row-major order, emitting
// one pixel per cycle (filled or outline) over a valid/ready stream.
module rect_raster
  import rect_pkg::*;
#(
  parameter int COORD_W = 16
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic [COORD_W-1:0] cmd_x0,
  input  logic [COORD_W-1:0] cmd_y0,
  input  logic [COORD_W-1:0] cmd_x1,
  input  logic [COORD_W-1:0] cmd_y1,
  input  logic               cmd_outline,
  output logic               pix_valid,
  input  logic               pix_ready,
  output logic [COORD_W-1:0] pix_x,
  output logic [COORD_W-1:0] pix_y,
  output logic               pix_last,
  output logic               busy
);

  localparam logic [COORD_W-1:0] ONE = COORD_W'(1);

  rect_state_t        state_q, state_d;
  logic [COORD_W-1:0] x_q, x_d, y_q, y_d;
  logic [COORD_W-1:0] xmin_q, xmin_d, xmax_q, xmax_d;
  logic [COORD_W-1:0] ymin_q, ymin_d, ymax_q, ymax_d;
  logic               mode_q, mode_d;
  logic               valid_q, valid_d;
  logic               last_q, last_d;
  logic               busy_q, busy_d;

  logic [COORD_W-1:0] n_xmin, n_xmax, n_ymin, n_ymax;
  logic [COORD_W-1:0] x_adv, y_adv;

  rect_corner_norm #(.COORD_W(COORD_W)) u_norm (
    .x0   (cmd_x0),
    .y0   (cmd_y0),
    .x1   (cmd_x1),
    .y1   (cmd_y1),
    .xmin (n_xmin),
    .xmax (n_xmax),
    .ymin (n_ymin),
    .ymax (n_ymax)
  );

  // Next coordinate after a transfer; compared against the max before incrementing
  // so a rectangle touching 2^COORD_W-1 never wraps.
  always_comb begin
    x_adv = x_q + ONE;
    y_adv = y_q;
    if (x_q == xmax_q) begin
      x_adv = xmin_q;
      y_adv = y_q + ONE;
    end else if (mode_q == MODE_OUTLINE && y_q != ymin_q && y_q != ymax_q
                 && x_q == xmin_q) begin
      x_adv = xmax_q;
    end
  end

  // NOTE: every signal written here gets a default first, so no path leaves one
  // unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    y_d     = y_q;
    xmin_d  = xmin_q;
    xmax_d  = xmax_q;
    ymin_d  = ymin_q;
    ymax_d  = ymax_q;
    mode_d  = mode_q;
    valid_d = valid_q;
    last_d  = last_q;
    busy_d  = busy_q;
    case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          state_d = EMIT;
          xmin_d  = n_xmin;
          xmax_d  = n_xmax;
          ymin_d  = n_ymin;
          ymax_d  = n_ymax;
          mode_d  = cmd_outline;
          x_d     = n_xmin;
          y_d     = n_ymin;
          valid_d = 1'b1;
          busy_d  = 1'b1;
          last_d  = (n_xmin == n_xmax) && (n_ymin == n_ymax);
        end
      end
      EMIT: begin
        if (pix_ready) begin
          if (last_q) begin
            state_d = IDLE;
            valid_d = 1'b0;
            busy_d  = 1'b0;
            last_d  = 1'b0;
          end else begin
            x_d    = x_adv;
            y_d    = y_adv;
            last_d = (x_adv == xmax_q) && (y_adv == ymax_q);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples the values from before this edge.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      x_q     <= '0;
      y_q     <= '0;
      xmin_q  <= '0;
      xmax_q  <= '0;
      ymin_q  <= '0;
      ymax_q  <= '0;
      mode_q  <= MODE_FILL;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
      xmin_q  <= xmin_d;
      xmax_q  <= xmax_d;
      ymin_q  <= ymin_d;
      ymax_q  <= ymax_d;
      mode_q  <= mode_d;
      valid_q <= valid_d;
      last_q  <= last_d;
      busy_q  <= busy_d;
    end
  end

  // Ready is held low while reset is asserted and never looks at pix_ready.
  assign cmd_ready = (state_q == IDLE) && !reset;
  assign pix_valid = valid_q;
  assign pix_x     = x_q;
  assign pix_y     = y_q;
  assign pix_last  = last_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_rect_raster.sv
// Directed bench for rect_raster: fill/outline/backpressure/reset on a 16-bit
// instance and range-edge/single-point on a 4-bit instance.
module tb_rect_raster;

  typedef struct {
    logic [15:0] x;
    logic [15:0] y;
  } pix_t;

  logic        clock = 1'b0;
  logic        reset;
  logic        cmd_valid, cmd_ready, cmd_outline;
  logic [15:0] cmd_x0, cmd_y0, cmd_x1, cmd_y1;
  logic        pix_valid, pix_ready, pix_last, busy;
  logic [15:0] pix_x, pix_y;

  logic        e_cmd_valid, e_cmd_ready, e_pix_valid, e_pix_last, e_busy;
  logic [3:0]  e_x0, e_y0, e_x1, e_y1, e_pix_x, e_pix_y;

  int   checks = 0;
  int   errors = 0;
  pix_t exp_q[$];

  always #5 clock = ~clock;

  rect_raster #(.COORD_W(16)) dut (
    .clock       (clock),
    .reset       (reset),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_x0      (cmd_x0),
    .cmd_y0      (cmd_y0),
    .cmd_x1      (cmd_x1),
    .cmd_y1      (cmd_y1),
    .cmd_outline (cmd_outline),
    .pix_valid   (pix_valid),
    .pix_ready   (pix_ready),
    .pix_x       (pix_x),
    .pix_y       (pix_y),
    .pix_last    (pix_last),
    .busy        (busy)
  );

  rect_raster #(.COORD_W(4)) dut4 (
    .clock       (clock),
    .reset       (reset),
    .cmd_valid   (e_cmd_valid),
    .cmd_ready   (e_cmd_ready),
    .cmd_x0      (e_x0),
    .cmd_y0      (e_y0),
    .cmd_x1      (e_x1),
    .cmd_y1      (e_y1),
    .cmd_outline (1'b0),
    .pix_valid   (e_pix_valid),
    .pix_ready   (1'b1),
    .pix_x       (e_pix_x),
    .pix_y       (e_pix_y),
    .pix_last    (e_pix_last),
    .busy        (e_busy)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic push(input int x, input int y);
    pix_t p;
    p.x = 16'(x);
    p.y = 16'(y);
    exp_q.push_back(p);
  endtask

  // Issues one command and consumes the pixels listed in exp_q; bp selects the
  // 1,0,0,1 ready pattern instead of ready held high.
  task automatic run_cmd(input string tag, input int x0, input int y0, input int x1,
                         input int y1, input logic outline, input bit bp);
    int idx = 0;
    int cyc = 0;
    int n   = exp_q.size();
    check({tag, "/cmd_ready_idle"}, 64'(cmd_ready), 64'd1);
    cmd_x0 = 16'(x0); cmd_y0 = 16'(y0);
    cmd_x1 = 16'(x1); cmd_y1 = 16'(y1);
    cmd_outline = outline;
    cmd_valid = 1'b1;
    @(negedge clock);
    cmd_valid = 1'b0;
    while (idx < n && cyc < 200) begin
      pix_ready = bp ? ((cyc % 4 == 0) || (cyc % 4 == 3)) : 1'b1;
      check({tag, "/valid"}, 64'(pix_valid), 64'd1);
      check({tag, $sformatf("/pix%0d", idx)}, {31'd0, pix_x, pix_y, pix_last},
            {31'd0, exp_q[idx].x, exp_q[idx].y, (idx == n - 1)});
      check({tag, "/busy"}, {cmd_ready, busy}, 64'b01);
      if (pix_ready && pix_valid) idx++;
      cyc++;
      @(negedge clock);
    end
    pix_ready = 1'b1;
    check({tag, "/count"}, 64'(idx), 64'(n));
    check({tag, "/done"}, {pix_valid, busy, cmd_ready}, 64'b001);
    exp_q.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    reset = 1'b1;
    cmd_valid = 1'b0; cmd_outline = 1'b0; pix_ready = 1'b1;
    cmd_x0 = '0; cmd_y0 = '0; cmd_x1 = '0; cmd_y1 = '0;
    e_cmd_valid = 1'b0; e_x0 = '0; e_y0 = '0; e_x1 = '0; e_y1 = '0;
    repeat (2) @(negedge clock);
    check("reset/outs", {pix_valid, pix_x, pix_y, pix_last, busy, cmd_ready},
          {1'b0, 16'd0, 16'd0, 1'b0, 1'b0, 1'b0});
    reset = 1'b0;
    #1;
    check("reset/cmd_ready_after", 64'(cmd_ready), 64'd1);
    @(negedge clock);

    // Filled 3x2
    push(2,3); push(3,3); push(4,3); push(2,4); push(3,4); push(4,4);
    run_cmd("fill", 2, 3, 4, 4, 1'b0, 1'b0);

    // Swapped corners give the same walk
    push(2,3); push(3,3); push(4,3); push(2,4); push(3,4); push(4,4);
    run_cmd("swap", 4, 4, 2, 3, 1'b0, 1'b0);

    // Outline 4x4: border only
    push(0,0); push(1,0); push(2,0); push(3,0);
    push(0,1); push(3,1); push(0,2); push(3,2);
    push(0,3); push(1,3); push(2,3); push(3,3);
    run_cmd("outline", 0, 0, 3, 3, 1'b1, 1'b0);

    // Width-2 outline and single-row outline
    push(5,1); push(6,1); push(5,2); push(6,2); push(5,3); push(6,3);
    run_cmd("outline_w2", 6, 3, 5, 1, 1'b1, 1'b0);
    push(1,9); push(2,9); push(3,9);
    run_cmd("outline_row", 3, 9, 1, 9, 1'b1, 1'b0);

    // Backpressure on 2x2 fill
    push(0,0); push(1,0); push(0,1); push(1,1);
    run_cmd("bp", 0, 0, 1, 1, 1'b0, 1'b1);

    // 16-bit top of range
    push(65534,65535); push(65535,65535);
    run_cmd("max16", 65535, 65535, 65534, 65535, 1'b0, 1'b0);

    // Reset after 3 transfers of a 3x3 fill, with a coincident command
    cmd_x0 = 16'd0; cmd_y0 = 16'd0; cmd_x1 = 16'd2; cmd_y1 = 16'd2; cmd_outline = 1'b0;
    cmd_valid = 1'b1;
    @(negedge clock);
    cmd_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check($sformatf("rst_mid/pix%0d", i), {pix_valid, pix_x, pix_y, pix_last},
            {1'b1, 16'(i), 16'd0, 1'b0});
      @(negedge clock);
    end
    reset = 1'b1;
    cmd_x0 = 16'd5; cmd_y0 = 16'd5; cmd_x1 = 16'd5; cmd_y1 = 16'd5;
    cmd_valid = 1'b1;
    @(negedge clock);
    check("rst_mid/during", {pix_valid, busy, cmd_ready}, 64'b000);
    reset = 1'b0;
    cmd_valid = 1'b0;
    #1;
    check("rst_mid/after", {pix_valid, busy, cmd_ready}, 64'b001);
    @(negedge clock);
    check("rst_mid/cmd_ignored", {pix_valid, busy, cmd_ready}, 64'b001);
    push(1,1);
    run_cmd("rst_point", 1, 1, 1, 1, 1'b0, 1'b0);

    // 4-bit range edge: (14,15)-(15,15)
    check("e/idle", 64'(e_cmd_ready), 64'd1);
    e_x0 = 4'd14; e_y0 = 4'd15; e_x1 = 4'd15; e_y1 = 4'd15;
    e_cmd_valid = 1'b1;
    @(negedge clock);
    e_cmd_valid = 1'b0;
    check("e/pix0", {e_pix_valid, e_pix_x, e_pix_y, e_pix_last, e_busy},
          {1'b1, 4'd14, 4'd15, 1'b0, 1'b1});
    @(negedge clock);
    check("e/pix1", {e_pix_valid, e_pix_x, e_pix_y, e_pix_last},
          {1'b1, 4'd15, 4'd15, 1'b1});
    @(negedge clock);
    check("e/done", {e_pix_valid, e_busy, e_cmd_ready}, 64'b001);
    @(negedge clock);
    check("e/no_wrap", {e_pix_valid, e_busy}, 64'b00);

    // 4-bit single point
    e_x0 = 4'd7; e_y0 = 4'd7; e_x1 = 4'd7; e_y1 = 4'd7;
    e_cmd_valid = 1'b1;
    @(negedge clock);
    e_cmd_valid = 1'b0;
    check("e/point", {e_pix_valid, e_pix_x, e_pix_y, e_pix_last},
          {1'b1, 4'd7, 4'd7, 1'b1});
    @(negedge clock);
    check("e/point_done", {e_pix_valid, e_busy, e_cmd_ready}, 64'b001);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
